// File: rtl/z3_master.sv
// Zorro III bus-master cycle generator: turns single-longword DMA commands into
// arbitrated Zorro III master cycles and returns read data and status.
module z3_master #(
  parameter int unsigned TIMEOUT = 32'd255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  output logic        ready,
  input  logic [31:0] req_addr,
  input  logic        req_read,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic        req_hold,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        BR_n,
  input  logic        BG_n,
  input  logic        FCS_n_in,
  input  logic        DTACK_n,
  input  logic        BERR_n,
  input  logic [31:0] D_IN,
  output logic        MASTER_OE,
  output logic [31:0] A_OUT,
  output logic [2:0]  FC,
  output logic        READ,
  output logic        FCS_n,
  output logic        DOE,
  output logic [3:0]  DS_n,
  output logic        D_OE,
  output logic [31:0] D_OUT
);

  localparam int unsigned CW = (TIMEOUT < 32'd2) ? 32'd1 : $clog2(TIMEOUT + 32'd1);
  localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ARB     = 4'd1,
    ST_ADDR    = 4'd2,
    ST_STROBE  = 4'd3,
    ST_DATA    = 4'd4,
    ST_WAIT    = 4'd5,
    ST_TERM    = 4'd6,
    ST_RELEASE = 4'd7,
    ST_HOLD    = 4'd8
  } state_t;

  state_t state_r, state_nxt_s;

  // Synchronizer bit order: [0] BG_n, [1] DTACK_n, [2] BERR_n, [3] FCS_n_in.
  logic [3:0] sync1_r, sync2_r;
  logic bg_n_s, dtack_n_s, berr_n_s, fcs_n_s;

  logic [31:0] cmd_addr_r, cmd_addr_nxt_s;
  logic        cmd_read_r, cmd_read_nxt_s;
  logic [3:0]  cmd_be_r, cmd_be_nxt_s;
  logic [31:0] cmd_wdata_r, cmd_wdata_nxt_s;
  logic        cmd_hold_r, cmd_hold_nxt_s;

  logic          gnt_q_r, gnt_q_nxt_s;
  logic          addr_vld_r, addr_vld_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          tmo_r, tmo_nxt_s;
  logic          err_pend_r, err_pend_nxt_s;
  logic [31:0]   rdata_pend_r, rdata_pend_nxt_s;

  logic        br_n_r, br_n_nxt_s;
  logic        master_oe_r, master_oe_nxt_s;
  logic [31:0] a_out_r, a_out_nxt_s;
  logic [2:0]  fc_r, fc_nxt_s;
  logic        read_r, read_nxt_s;
  logic        fcs_n_r, fcs_n_nxt_s;
  logic        doe_r, doe_nxt_s;
  logic [3:0]  ds_n_r, ds_n_nxt_s;
  logic        d_oe_r, d_oe_nxt_s;
  logic [31:0] d_out_r, d_out_nxt_s;
  logic [31:0] rdata_r, rdata_nxt_s;
  logic        done_r, done_nxt_s;
  logic        err_r, err_nxt_s;

  logic ready_s, accept_s, arb_ok_s;
  logic addr_lsb_unused_s;

  assign bg_n_s    = sync2_r[0];
  assign dtack_n_s = sync2_r[1];
  assign berr_n_s  = sync2_r[2];
  assign fcs_n_s   = sync2_r[3];

  // A lost grant in HOLD closes the door so no command is accepted into a dying tenure.
  assign ready_s  = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && !bg_n_s);
  assign accept_s = req && ready_s;
  assign arb_ok_s = !bg_n_s && fcs_n_s && dtack_n_s;
  assign addr_lsb_unused_s = ^req_addr[1:0];

  assign ready     = ready_s;
  assign done      = done_r;
  assign err       = err_r;
  assign rdata     = rdata_r;
  assign BR_n      = br_n_r;
  assign MASTER_OE = master_oe_r;
  assign A_OUT     = a_out_r;
  assign FC        = fc_r;
  assign READ      = read_r;
  assign FCS_n     = fcs_n_r;
  assign DOE       = doe_r;
  assign DS_n      = ds_n_r;
  assign D_OE      = d_oe_r;
  assign D_OUT     = d_out_r;

  // Two-flop synchronizers for the asynchronous bus handshake inputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_r <= 4'hF;
      sync2_r <= 4'hF;
    end else begin
      sync1_r <= {FCS_n_in, BERR_n, DTACK_n, BG_n};
      sync2_r <= sync1_r;
    end
  end

  // Next-state and next-output logic; every register defaults to holding.
  always_comb begin
    state_nxt_s      = state_r;
    cmd_addr_nxt_s   = cmd_addr_r;
    cmd_read_nxt_s   = cmd_read_r;
    cmd_be_nxt_s     = cmd_be_r;
    cmd_wdata_nxt_s  = cmd_wdata_r;
    cmd_hold_nxt_s   = cmd_hold_r;
    gnt_q_nxt_s      = 1'b0;
    addr_vld_nxt_s   = addr_vld_r;
    cnt_nxt_s        = cnt_r;
    tmo_nxt_s        = 1'b0;
    err_pend_nxt_s   = err_pend_r;
    rdata_pend_nxt_s = rdata_pend_r;
    br_n_nxt_s       = br_n_r;
    master_oe_nxt_s  = master_oe_r;
    a_out_nxt_s      = a_out_r;
    fc_nxt_s         = fc_r;
    read_nxt_s       = read_r;
    fcs_n_nxt_s      = fcs_n_r;
    doe_nxt_s        = doe_r;
    ds_n_nxt_s       = ds_n_r;
    d_oe_nxt_s       = d_oe_r;
    d_out_nxt_s      = d_out_r;
    rdata_nxt_s      = rdata_r;
    done_nxt_s       = 1'b0;
    err_nxt_s        = err_r;

    if (accept_s) begin
      cmd_addr_nxt_s  = {req_addr[31:2], 2'b00};
      cmd_read_nxt_s  = req_read;
      cmd_be_nxt_s    = req_be;
      cmd_wdata_nxt_s = req_wdata;
      cmd_hold_nxt_s  = req_hold;
    end else begin
      cmd_hold_nxt_s  = cmd_hold_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          br_n_nxt_s  = 1'b0;
          state_nxt_s = ST_ARB;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      // Grant conditions must hold on two consecutive samples before taking the bus.
      ST_ARB: begin
        if (arb_ok_s && gnt_q_r) begin
          master_oe_nxt_s = 1'b1;
          a_out_nxt_s     = cmd_addr_r;
          read_nxt_s      = cmd_read_r;
          fc_nxt_s        = 3'b101;
          addr_vld_nxt_s  = 1'b1;
          state_nxt_s     = ST_ADDR;
        end else begin
          gnt_q_nxt_s     = arb_ok_s;
        end
      end
      // Entered from HOLD the address still has to be loaded, so ADDR takes an extra cycle.
      ST_ADDR: begin
        if (addr_vld_r) begin
          fcs_n_nxt_s    = 1'b0;
          state_nxt_s    = ST_STROBE;
        end else begin
          a_out_nxt_s    = cmd_addr_r;
          read_nxt_s     = cmd_read_r;
          addr_vld_nxt_s = 1'b1;
        end
      end
      ST_STROBE: begin
        doe_nxt_s = 1'b1;
        if (!cmd_read_r) begin
          d_oe_nxt_s  = 1'b1;
          d_out_nxt_s = cmd_wdata_r;
        end else begin
          d_oe_nxt_s  = 1'b0;
        end
        state_nxt_s = ST_DATA;
      end
      ST_DATA: begin
        ds_n_nxt_s  = ~cmd_be_r;
        cnt_nxt_s   = {CW{1'b0}};
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_nxt_s = (cnt_r == TMO_C);
        cnt_nxt_s = (cnt_r == TMO_C) ? cnt_r : cnt_r + CW'(32'd1);
        if (!berr_n_s || tmo_r) begin
          err_pend_nxt_s = 1'b1;
          state_nxt_s    = ST_TERM;
        end else if (!dtack_n_s) begin
          err_pend_nxt_s = 1'b0;
          if (cmd_read_r) begin
            rdata_pend_nxt_s = D_IN;
          end else begin
            rdata_pend_nxt_s = rdata_pend_r;
          end
          state_nxt_s    = ST_TERM;
        end else begin
          state_nxt_s    = ST_WAIT;
        end
      end
      ST_TERM: begin
        fcs_n_nxt_s = 1'b1;
        ds_n_nxt_s  = 4'hF;
        doe_nxt_s   = 1'b0;
        d_oe_nxt_s  = 1'b0;
        done_nxt_s  = 1'b1;
        err_nxt_s   = err_pend_r;
        if (cmd_read_r && !err_pend_r) begin
          rdata_nxt_s = rdata_pend_r;
        end else begin
          rdata_nxt_s = rdata_r;
        end
        state_nxt_s = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (dtack_n_s && berr_n_s) begin
          if (cmd_hold_r) begin
            state_nxt_s     = ST_HOLD;
          end else begin
            br_n_nxt_s      = 1'b1;
            master_oe_nxt_s = 1'b0;
            fc_nxt_s        = 3'b000;
            state_nxt_s     = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      ST_HOLD: begin
        if (bg_n_s || (!accept_s && !req_hold)) begin
          br_n_nxt_s      = 1'b1;
          master_oe_nxt_s = 1'b0;
          fc_nxt_s        = 3'b000;
          state_nxt_s     = ST_IDLE;
        end else if (accept_s) begin
          addr_vld_nxt_s  = 1'b0;
          state_nxt_s     = ST_ADDR;
        end else begin
          state_nxt_s     = ST_HOLD;
        end
      end
      default: begin
        br_n_nxt_s      = 1'b1;
        master_oe_nxt_s = 1'b0;
        fc_nxt_s        = 3'b000;
        fcs_n_nxt_s     = 1'b1;
        doe_nxt_s       = 1'b0;
        ds_n_nxt_s      = 4'hF;
        d_oe_nxt_s      = 1'b0;
        state_nxt_s     = ST_IDLE;
      end
    endcase
  end

  // State, command and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= ST_IDLE;
      cmd_addr_r   <= 32'h0000_0000;
      cmd_read_r   <= 1'b1;
      cmd_be_r     <= 4'h0;
      cmd_wdata_r  <= 32'h0000_0000;
      cmd_hold_r   <= 1'b0;
      gnt_q_r      <= 1'b0;
      addr_vld_r   <= 1'b0;
      cnt_r        <= {CW{1'b0}};
      tmo_r        <= 1'b0;
      err_pend_r   <= 1'b0;
      rdata_pend_r <= 32'h0000_0000;
      br_n_r       <= 1'b1;
      master_oe_r  <= 1'b0;
      a_out_r      <= 32'h0000_0000;
      fc_r         <= 3'b000;
      read_r       <= 1'b1;
      fcs_n_r      <= 1'b1;
      doe_r        <= 1'b0;
      ds_n_r       <= 4'hF;
      d_oe_r       <= 1'b0;
      d_out_r      <= 32'h0000_0000;
      rdata_r      <= 32'h0000_0000;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cmd_addr_r   <= cmd_addr_nxt_s;
      cmd_read_r   <= cmd_read_nxt_s;
      cmd_be_r     <= cmd_be_nxt_s;
      cmd_wdata_r  <= cmd_wdata_nxt_s;
      cmd_hold_r   <= cmd_hold_nxt_s;
      gnt_q_r      <= gnt_q_nxt_s;
      addr_vld_r   <= addr_vld_nxt_s;
      cnt_r        <= cnt_nxt_s;
      tmo_r        <= tmo_nxt_s;
      err_pend_r   <= err_pend_nxt_s;
      rdata_pend_r <= rdata_pend_nxt_s;
      br_n_r       <= br_n_nxt_s;
      master_oe_r  <= master_oe_nxt_s;
      a_out_r      <= a_out_nxt_s;
      fc_r         <= fc_nxt_s;
      read_r       <= read_nxt_s;
      fcs_n_r      <= fcs_n_nxt_s;
      doe_r        <= doe_nxt_s;
      ds_n_r       <= ds_n_nxt_s;
      d_oe_r       <= d_oe_nxt_s;
      d_out_r      <= d_out_nxt_s;
      rdata_r      <= rdata_nxt_s;
      done_r       <= done_nxt_s;
      err_r        <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_z3_master.sv
// Directed self-checking bench for z3_master: read, write, delayed grant, bus error,
// timeout, held tenure and mid-cycle reset.
module tb_z3_master;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req;
  logic        ready;
  logic [31:0] req_addr;
  logic        req_read;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_hold;
  logic        done, err;
  logic [31:0] rdata;
  logic        BR_n, BG_n, FCS_n_in, DTACK_n, BERR_n;
  logic [31:0] D_IN;
  logic        MASTER_OE;
  logic [31:0] A_OUT;
  logic [2:0]  FC;
  logic        READ, FCS_n, DOE;
  logic [3:0]  DS_n;
  logic        D_OE;
  logic [31:0] D_OUT;

  int nchk = 0;
  int nerr = 0;
  int br_falls = 0;
  int n;
  int f0;

  z3_master #(.TIMEOUT(32'd16)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .ready(ready), .req_addr(req_addr),
    .req_read(req_read), .req_be(req_be), .req_wdata(req_wdata), .req_hold(req_hold),
    .done(done), .err(err), .rdata(rdata), .BR_n(BR_n), .BG_n(BG_n),
    .FCS_n_in(FCS_n_in), .DTACK_n(DTACK_n), .BERR_n(BERR_n), .D_IN(D_IN),
    .MASTER_OE(MASTER_OE), .A_OUT(A_OUT), .FC(FC), .READ(READ), .FCS_n(FCS_n),
    .DOE(DOE), .DS_n(DS_n), .D_OE(D_OE), .D_OUT(D_OUT)
  );

  always #5 CLK = ~CLK;

  always @(negedge BR_n) br_falls = br_falls + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic rd, input logic [3:0] be,
                       input logic [31:0] wd, input logic hold);
    req = 1'b1; req_addr = a; req_read = rd; req_be = be; req_wdata = wd; req_hold = hold;
    step();
    req = 1'b0;
  endtask

  task automatic wait_ds(output int cnt);
    cnt = 0;
    while (DS_n === 4'hF && cnt < 40) begin step(); cnt++; end
    chk("ds_wait_bound", {31'd0, DS_n !== 4'hF}, 32'd1);
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 60) begin step(); cnt++; end
    chk("done_wait_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_br_high(output int cnt);
    cnt = 0;
    while (BR_n !== 1'b1 && cnt < 40) begin step(); cnt++; end
    chk("br_release_bound", {31'd0, BR_n}, 32'd1);
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (ready !== 1'b1 && cnt < 40) begin step(); cnt++; end
    chk("hold_ready_bound", {31'd0, ready}, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_BR_n"}, {31'd0, BR_n}, 32'd1);
    chk({tag, "_MASTER_OE"}, {31'd0, MASTER_OE}, 32'd0);
    chk({tag, "_A_OUT"}, A_OUT, 32'd0);
    chk({tag, "_FC"}, {29'd0, FC}, 32'd0);
    chk({tag, "_READ"}, {31'd0, READ}, 32'd1);
    chk({tag, "_FCS_n"}, {31'd0, FCS_n}, 32'd1);
    chk({tag, "_DOE"}, {31'd0, DOE}, 32'd0);
    chk({tag, "_DS_n"}, {28'd0, DS_n}, 32'hF);
    chk({tag, "_D_OE"}, {31'd0, D_OE}, 32'd0);
    chk({tag, "_D_OUT"}, D_OUT, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    RESET = 1'b1; req = 1'b0; req_addr = 32'd0; req_read = 1'b0; req_be = 4'h0;
    req_wdata = 32'd0; req_hold = 1'b0; BG_n = 1'b1; FCS_n_in = 1'b1;
    DTACK_n = 1'b1; BERR_n = 1'b1; D_IN = 32'd0;
    repeat (3) step();
    chk_reset("reset");
    chk("reset_ready", {31'd0, ready}, 32'd1);
    RESET = 1'b0; BG_n = 1'b0;
    repeat (3) step();

    // Read with grant already stable: edge-by-edge pipeline
    issue(32'h0040_1237, 1'b1, 4'hF, 32'd0, 1'b0);
    chk("rd_e0_BR_n", {31'd0, BR_n}, 32'd0);
    chk("rd_e0_ready", {31'd0, ready}, 32'd0);
    step();
    chk("rd_e1_MASTER_OE", {31'd0, MASTER_OE}, 32'd0);
    step();
    chk("rd_e2_MASTER_OE", {31'd0, MASTER_OE}, 32'd1);
    chk("rd_e2_A_OUT", A_OUT, 32'h0040_1234);
    chk("rd_e2_FC", {29'd0, FC}, 32'd5);
    chk("rd_e2_READ", {31'd0, READ}, 32'd1);
    chk("rd_e2_FCS_n", {31'd0, FCS_n}, 32'd1);
    step();
    chk("rd_e3_FCS_n", {31'd0, FCS_n}, 32'd0);
    chk("rd_e3_DOE", {31'd0, DOE}, 32'd0);
    step();
    chk("rd_e4_DOE", {31'd0, DOE}, 32'd1);
    chk("rd_e4_D_OE", {31'd0, D_OE}, 32'd0);
    chk("rd_e4_DS_n", {28'd0, DS_n}, 32'hF);
    step();
    chk("rd_e5_DS_n", {28'd0, DS_n}, 32'h0);
    step(); step();
    DTACK_n = 1'b0; D_IN = 32'hDEAD_BEEF;
    wait_done(n);
    chk("rd_dtack_to_done", n, 32'd4);
    chk("rd_err", {31'd0, err}, 32'd0);
    chk("rd_rdata", rdata, 32'hDEAD_BEEF);
    chk("rd_done_FCS_n", {31'd0, FCS_n}, 32'd1);
    chk("rd_done_DS_n", {28'd0, DS_n}, 32'hF);
    chk("rd_done_BR_n", {31'd0, BR_n}, 32'd0);
    DTACK_n = 1'b1; D_IN = 32'd0;
    step();
    chk("rd_done_pulse", {31'd0, done}, 32'd0);
    chk("rd_rdata_hold", rdata, 32'hDEAD_BEEF);
    wait_br_high(n);
    chk("rd_br_release_delay", n, 32'd2);
    chk("rd_rel_MASTER_OE", {31'd0, MASTER_OE}, 32'd0);
    chk("rd_rel_FC", {29'd0, FC}, 32'd0);

    // Write with partial byte enables
    issue(32'h0080_0010, 1'b0, 4'b1100, 32'h1234_5678, 1'b0);
    step(); step();
    chk("wr_READ", {31'd0, READ}, 32'd0);
    step(); step();
    chk("wr_e4_D_OE", {31'd0, D_OE}, 32'd1);
    chk("wr_e4_D_OUT", D_OUT, 32'h1234_5678);
    step();
    chk("wr_DS_n", {28'd0, DS_n}, 32'h3);
    DTACK_n = 1'b0;
    step(); step(); step();
    chk("wr_term_D_OE", {31'd0, D_OE}, 32'd1);
    step();
    chk("wr_done", {31'd0, done}, 32'd1);
    chk("wr_err", {31'd0, err}, 32'd0);
    chk("wr_done_D_OE", {31'd0, D_OE}, 32'd0);
    chk("wr_rdata_kept", rdata, 32'hDEAD_BEEF);
    DTACK_n = 1'b1;
    wait_br_high(n);

    // Grant withheld for 20 cycles
    BG_n = 1'b1;
    repeat (3) step();
    issue(32'h0000_1000, 1'b1, 4'hF, 32'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("nogrant_BR_FCS_OE", {29'd0, BR_n, FCS_n, MASTER_OE}, 32'b010);
      step();
    end
    BG_n = 1'b0;
    wait_ds(n);
    D_IN = 32'hCAFE_0001; DTACK_n = 1'b0;
    wait_done(n);
    chk("grant_late_err", {31'd0, err}, 32'd0);
    chk("grant_late_rdata", rdata, 32'hCAFE_0001);
    DTACK_n = 1'b1;
    wait_br_high(n);

    // Bus error, then a normal read
    issue(32'h0000_2000, 1'b1, 4'hF, 32'd0, 1'b0);
    wait_ds(n);
    BERR_n = 1'b0; D_IN = 32'hFFFF_FFFF;
    wait_done(n);
    chk("berr_latency", n, 32'd4);
    chk("berr_err", {31'd0, err}, 32'd1);
    chk("berr_rdata_kept", rdata, 32'hCAFE_0001);
    BERR_n = 1'b1;
    step();
    chk("berr_err_hold", {31'd0, err}, 32'd1);
    wait_br_high(n);
    issue(32'h0000_2004, 1'b1, 4'hF, 32'd0, 1'b0);
    wait_ds(n);
    D_IN = 32'h0BAD_F00D; DTACK_n = 1'b0;
    wait_done(n);
    chk("after_berr_err", {31'd0, err}, 32'd0);
    chk("after_berr_rdata", rdata, 32'h0BAD_F00D);
    DTACK_n = 1'b1;
    wait_br_high(n);

    // No response: timeout
    issue(32'h0000_3000, 1'b1, 4'hF, 32'd0, 1'b0);
    wait_ds(n);
    wait_done(n);
    chk("tmo_latency", n, 32'd19);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_DS_n", {28'd0, DS_n}, 32'hF);
    chk("tmo_FCS_n", {31'd0, FCS_n}, 32'd1);
    chk("tmo_DOE", {31'd0, DOE}, 32'd0);
    wait_br_high(n);

    // Held tenure: two commands, one bus request
    f0 = br_falls;
    issue(32'h0000_4000, 1'b1, 4'hF, 32'd0, 1'b1);
    wait_ds(n);
    chk("hold1_ds_latency", n, 32'd5);
    D_IN = 32'h1111_2222; DTACK_n = 1'b0;
    wait_done(n);
    chk("hold1_rdata", rdata, 32'h1111_2222);
    DTACK_n = 1'b1;
    wait_ready(n);
    chk("hold_BR_n", {31'd0, BR_n}, 32'd0);
    chk("hold_MASTER_OE", {31'd0, MASTER_OE}, 32'd1);
    chk("hold_FCS_n", {31'd0, FCS_n}, 32'd1);
    issue(32'h0000_4010, 1'b0, 4'b0011, 32'hA5A5_5A5A, 1'b1);
    wait_ds(n);
    chk("hold2_ds_latency", n, 32'd4);
    chk("hold2_DS_n", {28'd0, DS_n}, 32'hC);
    chk("hold2_A_OUT", A_OUT, 32'h0000_4010);
    DTACK_n = 1'b0;
    wait_done(n);
    chk("hold2_err", {31'd0, err}, 32'd0);
    DTACK_n = 1'b1;
    wait_ready(n);
    req_hold = 1'b0;
    step();
    chk("hold_release_BR_n", {31'd0, BR_n}, 32'd1);
    chk("hold_release_OE", {31'd0, MASTER_OE}, 32'd0);
    chk("hold_one_tenure", br_falls - f0, 32'd1);

    // Reset in the middle of WAIT
    issue(32'h0000_5000, 1'b1, 4'hF, 32'd0, 1'b0);
    wait_ds(n);
    step(); step();
    RESET = 1'b1;
    step();
    chk_reset("midrst");
    RESET = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/z3_master.md
# z3_master

Zorro III bus-master cycle generator for the A4092. It turns single-longword transfer commands from the local DMA side into arbitrated Zorro III master cycles. It requests the bus, drives address, FCS_n, DOE and DS_n, and waits for the addressed slave's DTACK_n or BERR_n. It then returns read data and status to the requester. It sits between the NCR DMA datapath and the bus buffers, and is the initiator counterpart of the card's slave-side cycle logic.

## Interface
- TIMEOUT, 255: cycles to wait for DTACK_n/BERR_n after DS_n assertion before the cycle is flagged as an error.
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- req  in  1  command valid.
- ready  out  1  command accepted when req && ready; combinational, high in IDLE and HOLD.
- req_addr  in  32  longword address; bits [1:0] ignored, driven as 0.
- req_read  in  1  1 = read, 0 = write.
- req_be  in  4  active-high byte enables; bit 3 = D[31:24].
- req_wdata  in  32  write data.
- req_hold  in  1  keep bus ownership after this transfer.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; BERR_n or timeout.
- rdata  out  32  read data, valid from done until next done.
- BR_n  out  1  bus request.
- BG_n  in  1  bus grant.
- FCS_n_in  in  1  bus FCS_n sense (bus-free check).
- DTACK_n  in  1  slave acknowledge.
- BERR_n  in  1  bus error.
- D_IN  in  32  bus data in.
- MASTER_OE  out  1  enables address/control drivers.
- A_OUT  out  32  bus address.
- FC  out  3  function code, 3'b101 while owning.
- READ  out  1  bus READ.
- FCS_n  out  1  full cycle strobe.
- DOE  out  1  data output enable phase.
- DS_n  out  4  data strobes.
- D_OE  out  1  enables data drivers (writes only).
- D_OUT  out  32  write data to bus.

## Operation
- Four 2-flop synchronizers: BG_n, DTACK_n, BERR_n, FCS_n_in. Reset value 1. Decisions use only the synchronized values.
- Reset values: BR_n=1, MASTER_OE=0, A_OUT=0, FC=0, READ=1, FCS_n=1, DOE=0, DS_n=4'hF, D_OE=0, D_OUT=0, rdata=0, done=0, err=0. State = IDLE.
- A command is latched (addr, read, be, wdata, hold) on the accept edge.
- IDLE: on accept, BR_n<=0 and go to ARB.
- ARB: wait for BG_n, FCS_n_in and DTACK_n synced to read 0, 1, 1. Then go to ADDR with MASTER_OE<=1, A_OUT<=addr, READ<=read, FC<=101.
- ADDR: one cycle with address valid and FCS_n high. Then FCS_n<=0 and go to STROBE.
- STROBE: DOE<=1. For writes, D_OE<=1 and D_OUT<=wdata. Go to DATA.
- DATA: DS_n<=~be, timeout counter<=0. Go to WAIT.
- WAIT: the counter increments each cycle and saturates.
  - DTACK sync low: rdata<=D_IN on reads, go to TERM with err=0.
  - BERR sync low, or counter==TIMEOUT: go to TERM with err=1.
  - BERR takes priority when it arrives together with DTACK.
- TERM: FCS_n<=1, DS_n<=F, DOE<=0, D_OE<=0, done<=1 for one cycle, err set as above. Go to RELEASE.
- RELEASE: wait for DTACK and BERR sync both high.
  - If the latched hold=1, go to HOLD.
  - Otherwise BR_n<=1, MASTER_OE<=0, FC<=0, and go to IDLE.
- HOLD: BR_n stays 0, MASTER_OE stays 1, FCS_n stays high.
  - On accept, go directly to ADDR; no re-arbitration.
  - If req_hold=0 and no accept, release as in RELEASE and go to IDLE.
  - If BG sync goes high while in HOLD, release immediately.
- BR_n stays low for the whole tenure, from the ARB entry edge until the release edge.
- err holds its value until the next done.

## Timing
- Grant already stable at the pins: accept edge 0 → ARB (BR_n low) → ADDR at edge 2 → FCS_n low at edge 3 → DOE at edge 4 → DS_n low at edge 5.
- Accept in HOLD: DS_n low 4 edges later.
- DTACK_n pin low at cycle t: state leaves WAIT at edge t+3 (2 synchronizer edges plus 1); done rises at edge t+4.
- Timeout: err reported TIMEOUT+3 edges after DS_n assertion.
- Reset mid-cycle: all outputs return to reset values at the next edge, with no done pulse.
- A4092 self-addressed cycles are not blocked here; arbitration and slave decode prevent them.

## Test plan
- Read, BG_n held low, DTACK_n asserted 2 cycles after DS_n with D_IN=32'hDEADBEEF → done with err=0, rdata=DEADBEEF, FCS_n high at done, BR_n high 2+ cycles later.
- Write with be=4'b1100, wdata=32'h12345678 → DS_n=4'b0011, D_OE=1 and D_OUT=12345678 from STROBE until TERM, READ=0.
- BG_n withheld 20 cycles → BR_n low throughout, FCS_n never asserted, cycle completes normally after grant.
- BERR_n asserted instead of DTACK_n → done with err=1; next command succeeds.
- No response, TIMEOUT=16 → done with err=1 exactly 19 edges after DS_n low; strobes released.
- Two commands with req_hold=1, then req_hold=0 → one BR_n low tenure covering both cycles, no second ARB; RESET asserted during WAIT → all outputs at reset values next edge.
